opamp_sd_decimator: RTL and testbench

- Digital back-end that consumes the two-stage op-amp's output once the op-amp is wired as a first-order sigma-delta modulator (integrator plus comparator).
- Synchronises the comparator bit and drives the 1-bit feedback DAC back into the analog loop.
- Counts ones over a window of 2^OSR_LOG2 cycles and presents the result with a one-cycle valid strobe.
- Sits between the analog macro's comparator output and the digital uo_out/uio pins.

---
 rtl/opamp_sd_decimator.sv | 186 ++++++++++++++++++
 tb/tb_opamp_sd_decimator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opamp_sd_decimator.sv
// Sigma-delta back-end for the op-amp modulator: sync, feedback DAC, ones-count decimator.
// Optional serial result output enabled by defining OPAMP_SD_SERIAL_EN.
module opamp_sd_decimator #(
   parameter int OSR_LOG2   = 8,
   parameter int SETTLE_CYC = 16,
   parameter int RES_W      = OSR_LOG2 + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             comp_in,
   input  logic             start,
   input  logic             cont,
   input  logic             abort,
   output logic             fb_out,
   output logic             busy,
   output logic [RES_W-1:0] result,
   output logic             result_valid,
   output logic             rail,
   output logic             ser_out,
   output logic             ser_frame
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ACCUM  = 2'd2
   } state_t;

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SET_LAST =
      SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [OSR_LOG2-1:0] WIN_LAST = {OSR_LOG2{1'b1}};
   localparam logic [RES_W-1:0] FULL = RES_W'(2 ** OSR_LOG2);

   state_t              state_q, state_d;
   logic                sync1_q, comp_s_q, fb_q;
   logic                busy_q, busy_d;
   logic [SET_W-1:0]    set_q, set_d;
   logic [OSR_LOG2-1:0] win_q, win_d;
   logic [RES_W-1:0]    cnt_q, cnt_d;
   logic [RES_W-1:0]    result_q, result_d;
   logic                valid_q, valid_d;
   logic                rail_q, rail_d;
   logic [RES_W-1:0]    final_cnt;
   logic                run;

   assign run = ena & ~abort;

   // State and datapath registers, synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sync1_q  <= 1'b0;
         comp_s_q <= 1'b0;
         fb_q     <= 1'b0;
         busy_q   <= 1'b0;
         set_q    <= '0;
         win_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         rail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= comp_in;
         comp_s_q <= sync1_q;
         fb_q     <= comp_s_q;
         busy_q   <= busy_d;
         set_q    <= set_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         rail_q   <= rail_d;
      end
   end

   // Next-state: abort or disable always returns to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start && run)
               state_d = (SETTLE_CYC == 0) ? ACCUM : SETTLE;
         end
         SETTLE: begin
            if (!run)
               state_d = IDLE;
            else if (set_q == SET_LAST)
               state_d = ACCUM;
         end
         ACCUM: begin
            if (!run)
               state_d = IDLE;
            else if (win_q == WIN_LAST)
               state_d = cont ? ACCUM : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Counters and result capture; the final sample is folded into the result
   always_comb begin
      final_cnt = cnt_q + RES_W'(comp_s_q);
      set_d     = set_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      rail_d    = rail_q;
      valid_d   = 1'b0;
      busy_d    = (state_d != IDLE);
      unique case (state_q)
         SETTLE: begin
            if (!run || set_q == SET_LAST)
               set_d = '0;
            else
               set_d = set_q + SET_W'(1);
         end
         ACCUM: begin
            if (!run) begin
               win_d = '0;
               cnt_d = '0;
            end else begin
               win_d = win_q + OSR_LOG2'(1);
               cnt_d = final_cnt;
               if (win_q == WIN_LAST) begin
                  cnt_d    = '0;
                  result_d = final_cnt;
                  valid_d  = 1'b1;
                  rail_d   = (final_cnt == '0) || (final_cnt == FULL);
               end
            end
         end
         default: begin
            set_d = '0;
            win_d = '0;
            cnt_d = '0;
         end
      endcase
   end

   assign fb_out       = fb_q;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = valid_q;
   assign rail         = rail_q;

`ifdef OPAMP_SD_SERIAL_EN
   localparam int FRM_W = $clog2(RES_W + 1);

   logic [RES_W-1:0] sh_q, sh_d;
   logic [FRM_W-1:0] frm_q, frm_d;

   // Shift register: each strobe (re)loads and restarts an MSB-first frame
   always_comb begin
      sh_d  = sh_q;
      frm_d = frm_q;
      if (valid_q) begin
         sh_d  = result_q;
         frm_d = FRM_W'(RES_W);
      end else if (frm_q != '0) begin
         sh_d  = {sh_q[RES_W-2:0], 1'b0};
         frm_d = frm_q - FRM_W'(1);
      end
   end

   // Serial frame registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q  <= '0;
         frm_q <= '0;
      end else begin
         sh_q  <= sh_d;
         frm_q <= frm_d;
      end
   end

   assign ser_frame = (frm_q != '0);
   assign ser_out   = sh_q[RES_W-1] & ser_frame;
`else
   assign ser_out   = 1'b0;
   assign ser_frame = 1'b0;
`endif

endmodule

// File: tb/tb_opamp_sd_decimator.sv
// Directed bench for opamp_sd_decimator with OSR_LOG2=4, SETTLE_CYC=2.
// Serial frame checks follow OPAMP_SD_SERIAL_EN.
module tb_opamp_sd_decimator;

   localparam int OSR_LOG2   = 4;
   localparam int SETTLE_CYC = 2;
   localparam int RES_W      = OSR_LOG2 + 1;

   logic             clk = 1'b0;
   logic             rst_n, ena, comp_in, start, cont, abort;
   logic             fb_out, busy, result_valid, rail, ser_out, ser_frame;
   logic [RES_W-1:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int mode;
      int exp_res;
      bit exp_rail;
   } vec_t;

   vec_t vecs[6];

   opamp_sd_decimator #(
      .OSR_LOG2  (OSR_LOG2),
      .SETTLE_CYC(SETTLE_CYC),
      .RES_W     (RES_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .comp_in     (comp_in),
      .start       (start),
      .cont        (cont),
      .abort       (abort),
      .fb_out      (fb_out),
      .busy        (busy),
      .result      (result),
      .result_valid(result_valid),
      .rail        (rail),
      .ser_out     (ser_out),
      .ser_frame   (ser_frame)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Comparator pattern; cycles 1..16 of a conversion are the counted samples
   function automatic logic pat(input int mode, input int i);
      case (mode)
         0: return 1'b1;
         1: return i[0];
         2: return 1'b0;
         3: return (i >= 1 && i <= 9);
         4: return (i % 4 == 0);
         default: return (i >= 1 && i <= 15);
      endcase
   endfunction

   task automatic do_conv(input int mode, input int exp_res,
                          input bit exp_rail, input int restart_at);
      int early;
      logic [4:0] r;
      logic eb, ef;
      early = 0;
      r = 5'(exp_res);
      start = 1'b1;
      comp_in = pat(mode, 0);
      step();
      start = 1'b0;
      chk("busy_rise", busy, 1);
      for (int i = 1; i <= 18; i++) begin
         comp_in = pat(mode, i);
         if (i == restart_at) start = 1'b1;
         step();
         start = 1'b0;
         if (i < 18 && result_valid) early++;
      end
      chk("no_early_strobe", early, 0);
      chk("strobe_at_19", result_valid, 1);
      chk("result", result, exp_res);
      chk("rail", rail, exp_rail);
      comp_in = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         step();
         if (k == 0) begin
            chk("strobe_one_cycle", result_valid, 0);
            chk("busy_fall", busy, 0);
         end
`ifdef OPAMP_SD_SERIAL_EN
         ef = (k < 5);
         eb = (k < 5) ? r[4-k] : 1'b0;
`else
         ef = 1'b0;
         eb = 1'b0;
`endif
         chk("ser_frame", ser_frame, ef);
         chk("ser_out", ser_out, eb);
      end
   endtask

   initial begin
      int cnt;
      int s_cnt;
      int s_pos[3];

      vecs[0] = '{mode: 0, exp_res: 16, exp_rail: 1'b1};
      vecs[1] = '{mode: 1, exp_res: 8,  exp_rail: 1'b0};
      vecs[2] = '{mode: 2, exp_res: 0,  exp_rail: 1'b1};
      vecs[3] = '{mode: 3, exp_res: 9,  exp_rail: 1'b0};
      vecs[4] = '{mode: 4, exp_res: 4,  exp_rail: 1'b0};
      vecs[5] = '{mode: 5, exp_res: 15, exp_rail: 1'b0};

      rst_n = 1'b0;
      ena = 1'b1;
      comp_in = 1'b1;
      start = 1'b0;
      cont = 1'b0;
      abort = 1'b0;
      step();
      step();
      step();
      chk("rst_fb", fb_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_rail", rail, 0);
      chk("rst_ser", {ser_out, ser_frame}, 0);
      rst_n = 1'b1;
      step();
      step();
      chk("fb_edge2", fb_out, 0);
      step();
      chk("fb_edge3", fb_out, 1);

      for (int v = 0; v < 6; v++)
         do_conv(vecs[v].mode, vecs[v].exp_res, vecs[v].exp_rail, 0);

      // start while busy must not restart the conversion
      do_conv(0, 16, 1'b1, 8);

      // abort in ACCUM cycle 7 after a result of 8
      do_conv(1, 8, 1'b0, 0);
      start = 1'b1;
      comp_in = 1'b1;
      step();
      start = 1'b0;
      cnt = 0;
      for (int i = 1; i <= 24; i++) begin
         if (i == 9) abort = 1'b1;
         step();
         abort = 1'b0;
         if (i == 9) chk("abort_busy", busy, 0);
         if (result_valid) cnt++;
      end
      chk("abort_no_strobe", cnt, 0);
      chk("abort_result", result, 8);
      chk("abort_rail", rail, 0);

      // abort on the window-end edge wins
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         if (i == 18) abort = 1'b1;
         step();
         abort = 1'b0;
      end
      chk("endabort_valid", result_valid, 0);
      chk("endabort_result", result, 8);
      chk("endabort_busy", busy, 0);

      // start with abort, or with ena low, stays idle
      start = 1'b1;
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("start_abort_idle", busy, 0);
      ena = 1'b0;
      step();
      start = 1'b0;
      chk("start_noena_idle", busy, 0);
      ena = 1'b1;

      // ena low mid-conversion aborts
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 6; i++) step();
      chk("ena_busy_pre", busy, 1);
      ena = 1'b0;
      step();
      ena = 1'b1;
      chk("ena_drop_busy", busy, 0);
      for (int i = 0; i < 20; i++) step();
      chk("ena_drop_result", result, 8);

      // continuous mode, 1-of-4 duty, cont dropped in the third window
      s_cnt = 0;
      s_pos = '{0, 0, 0};
      cont = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         comp_in = pat(4, n);
         start = (n == 1);
         if (n == 40) cont = 1'b0;
         step();
         start = 1'b0;
         if (result_valid) begin
            if (s_cnt < 3) s_pos[s_cnt] = n;
            s_cnt++;
            chk("cont_result", result, 4);
         end
      end
      chk("cont_strobes", s_cnt, 3);
      chk("cont_pos0", s_pos[0], 19);
      chk("cont_pos1", s_pos[1], 35);
      chk("cont_pos2", s_pos[2], 51);
      chk("cont_idle", busy, 0);

      // reset in the middle of a conversion
      start = 1'b1;
      comp_in = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) step();
      rst_n = 1'b0;
      step();
      chk("midrst_busy", busy, 0);
      chk("midrst_result", result, 0);
      chk("midrst_valid", result_valid, 0);
      chk("midrst_fb", fb_out, 0);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (result_valid) cnt++;
      end
      chk("midrst_no_strobe", cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
